// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, FSM states,
// instruction classes and the control-signal bundle driven into the datapath.
package cu_pkg;

   localparam int unsigned OP_W = 5;

   localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
   localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
   localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
   localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
   localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
   localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
   localparam logic [OP_W-1:0] OP_IN   = 5'b10101;
   localparam logic [OP_W-1:0] OP_OUT  = 5'b10110;
   localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
   localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

   typedef enum logic [3:0] {
      ST_RESET, ST_FETCH0, ST_FETCH1, ST_FETCH2,
      ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
   } state_e;

   typedef enum logic [3:0] {
      CL_ALU3, CL_ADDI, CL_LDI, CL_MULDIV, CL_MFHI, CL_MFLO,
      CL_IN, CL_OUT, CL_BR, CL_NOP, CL_HALT, CL_ILLEGAL
   } iclass_e;

   // Field order matches the top-level port concatenation, MSB first.
   typedef struct packed {
      logic pc_out, zlow_out, zhigh_out, mdr_out, c_out, in_port_out, lo_out, hi_out, ba_out, r_out;
      logic mar_in, pc_in, mdr_in, ir_in, y_in, inc_pc, hi_in, lo_in, c_in, in_in, out_in, z_in, con_in, r_in;
      logic gra, grb, grc, read, write;
      logic alu_add, alu_sub, alu_mul, alu_div, alu_and, alu_or;
   } ctrl_t;

endpackage

// File: rtl/cu_opcode_decode.sv
// Combinational opcode -> instruction-class decode for the control unit.
module cu_opcode_decode
   import cu_pkg::*;
#(
   parameter int unsigned OPCODE_W = OP_W
) (
   input  logic [OPCODE_W-1:0] opcode,
   output iclass_e             iclass_c
);

   always_comb begin
      iclass_c = CL_ILLEGAL;
      case (opcode)
         OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB),
         OPCODE_W'(OP_AND), OPCODE_W'(OP_OR):   iclass_c = CL_ALU3;
         OPCODE_W'(OP_ADDI):                    iclass_c = CL_ADDI;
         OPCODE_W'(OP_LDI):                     iclass_c = CL_LDI;
         OPCODE_W'(OP_MUL), OPCODE_W'(OP_DIV):  iclass_c = CL_MULDIV;
         OPCODE_W'(OP_MFHI):                    iclass_c = CL_MFHI;
         OPCODE_W'(OP_MFLO):                    iclass_c = CL_MFLO;
         OPCODE_W'(OP_IN):                      iclass_c = CL_IN;
         OPCODE_W'(OP_OUT):                     iclass_c = CL_OUT;
         OPCODE_W'(OP_BR):                      iclass_c = CL_BR;
         OPCODE_W'(OP_NOP):                     iclass_c = CL_NOP;
         OPCODE_W'(OP_HALT):                    iclass_c = CL_HALT;
         default:                               iclass_c = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer driving the datapath control lines (fetch + per-opcode execute).
// Optional CU_STOP_PIN_EN adds a stop input that diverts the end of an instruction into HALT.
module control_unit
   import cu_pkg::*;
#(
   parameter int unsigned IR_W            = 32,
   parameter int unsigned OPCODE_W        = 5,
   parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [IR_W-1:0] ir,
   input  logic            con_ff,
`ifdef CU_STOP_PIN_EN
   input  logic            stop,
`endif
   output logic            run,
   output logic            PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout, BAout, Rout,
   output logic            MARIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn, RIn,
   output logic            Gra, Grb, Grc, read, write,
   output logic            add, subtract, multiply, divide, andSignal, orSignal
);

   state_e              state_q, state_nxt;
   logic [OPCODE_W-1:0] op_q;
   iclass_e             iclass;
   ctrl_t               ctrl;
   logic                last_step;
   logic                stop_req;
   logic                unused_ir_low;

`ifdef CU_STOP_PIN_EN
   assign stop_req = stop;
`else
   assign stop_req = 1'b0;
`endif

   // Operand/immediate fields are consumed by the datapath, not here.
   assign unused_ir_low = ^ir[IR_W-OPCODE_W-1:0];

   cu_opcode_decode #(.OPCODE_W(OPCODE_W)) u_decode (
      .opcode   (op_q),
      .iclass_c (iclass)
   );

   // State register; opcode captured on the FETCH2 -> T3 edge.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= ST_RESET;
         op_q    <= '0;
      end else begin
         state_q <= state_nxt;
         if (state_q == ST_FETCH2) op_q <= ir[IR_W-1 -: OPCODE_W];
      end
   end

   always_comb begin
      state_nxt = state_q;
      ctrl      = '0;
      last_step = 1'b0;
      run       = (state_q != ST_RESET) && (state_q != ST_HALT);
      case (state_q)
         ST_RESET:  state_nxt = ST_FETCH0;
         ST_FETCH0: begin
            ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
            state_nxt = ST_FETCH1;
         end
         ST_FETCH1: begin
            ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            state_nxt = ST_FETCH2;
         end
         ST_FETCH2: begin
            ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            state_nxt = ST_T3;
         end
         ST_T3: begin
            state_nxt = ST_T4;
            case (iclass)
               CL_ALU3, CL_ADDI: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
               CL_LDI:    begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
               CL_MULDIV: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
               CL_MFHI:   begin ctrl.gra = 1'b1; ctrl.r_in = 1'b1; ctrl.hi_out = 1'b1; last_step = 1'b1; end
               CL_MFLO:   begin ctrl.gra = 1'b1; ctrl.r_in = 1'b1; ctrl.lo_out = 1'b1; last_step = 1'b1; end
               CL_IN:     begin ctrl.gra = 1'b1; ctrl.r_in = 1'b1; ctrl.in_port_out = 1'b1; last_step = 1'b1; end
               CL_OUT:    begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.out_in = 1'b1; last_step = 1'b1; end
               CL_BR:     begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
               CL_HALT:   state_nxt = ST_HALT;
               CL_ILLEGAL: begin
                  if (HALT_ON_ILLEGAL) state_nxt = ST_HALT;
                  else                 last_step = 1'b1;
               end
               default:   last_step = 1'b1;
            endcase
         end
         ST_T4: begin
            state_nxt = ST_T5;
            case (iclass)
               CL_ALU3: begin
                  ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                  ctrl.alu_add = (op_q == OPCODE_W'(OP_ADD));
                  ctrl.alu_sub = (op_q == OPCODE_W'(OP_SUB));
                  ctrl.alu_and = (op_q == OPCODE_W'(OP_AND));
                  ctrl.alu_or  = (op_q == OPCODE_W'(OP_OR));
               end
               CL_ADDI, CL_LDI: begin ctrl.c_out = 1'b1; ctrl.alu_add = 1'b1; ctrl.z_in = 1'b1; end
               CL_MULDIV: begin
                  ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                  ctrl.alu_mul = (op_q == OPCODE_W'(OP_MUL));
                  ctrl.alu_div = (op_q == OPCODE_W'(OP_DIV));
               end
               CL_BR:   begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
               default: last_step = 1'b1;
            endcase
         end
         ST_T5: begin
            state_nxt = ST_T6;
            case (iclass)
               CL_ALU3, CL_ADDI, CL_LDI: begin
                  ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; last_step = 1'b1;
               end
               CL_MULDIV: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
               CL_BR:     begin ctrl.c_out = 1'b1; ctrl.alu_add = 1'b1; ctrl.z_in = 1'b1; end
               default:   last_step = 1'b1;
            endcase
         end
         ST_T6: begin
            last_step = 1'b1;
            case (iclass)
               CL_MULDIV: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
               CL_BR:     begin ctrl.zlow_out = 1'b1; ctrl.pc_in = con_ff; end
               default:   ;
            endcase
         end
         ST_HALT:   state_nxt = ST_HALT;
         default:   state_nxt = ST_RESET;
      endcase
      if (last_step) state_nxt = stop_req ? ST_HALT : ST_FETCH0;
   end

   assign {PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout, BAout, Rout,
           MARIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn, RIn,
           Gra, Grb, Grc, read, write,
           add, subtract, multiply, divide, andSignal, orSignal} = ctrl;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a per-instruction reference model queues one expected
// control vector per clock; a negedge monitor pops and compares against the DUT outputs.
module tb_control_unit;

   typedef logic [35:0] vec_t;
   localparam bit HALT_ILL = 1'b0;

   localparam vec_t RUN    = 36'h1 << 0,  PCOUT  = 36'h1 << 1,  ZLOW   = 36'h1 << 2,  ZHIGH  = 36'h1 << 3;
   localparam vec_t MDROUT = 36'h1 << 4,  COUT   = 36'h1 << 5,  INPORT = 36'h1 << 6,  LOOUT  = 36'h1 << 7;
   localparam vec_t HIOUT  = 36'h1 << 8,  BAOUT  = 36'h1 << 9,  ROUT   = 36'h1 << 10, MARIN  = 36'h1 << 11;
   localparam vec_t PCIN   = 36'h1 << 12, MDRIN  = 36'h1 << 13, IRIN   = 36'h1 << 14, YIN    = 36'h1 << 15;
   localparam vec_t INCPC  = 36'h1 << 16, HIIN   = 36'h1 << 17, LOIN   = 36'h1 << 18, CIN    = 36'h1 << 19;
   localparam vec_t ININ   = 36'h1 << 20, OUTIN  = 36'h1 << 21, ZIN    = 36'h1 << 22, CONIN  = 36'h1 << 23;
   localparam vec_t RIN    = 36'h1 << 24, GRA    = 36'h1 << 25, GRB    = 36'h1 << 26, GRC    = 36'h1 << 27;
   localparam vec_t RD     = 36'h1 << 28, WR     = 36'h1 << 29, ADD    = 36'h1 << 30, SUB    = 36'h1 << 31;
   localparam vec_t MUL    = 36'h1 << 32, DIV    = 36'h1 << 33, ANDS   = 36'h1 << 34, ORS    = 36'h1 << 35;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] ir = '0;
   logic        con_ff = 1'b0;
`ifdef CU_STOP_PIN_EN
   logic        stop = 1'b0;
`endif
   logic run, PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout, BAout, Rout;
   logic MARIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn, RIn;
   logic Gra, Grb, Grc, read, write, add, subtract, multiply, divide, andSignal, orSignal;

   vec_t act;
   vec_t exp_q[$];
   vec_t mdl_q[$];
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   control_unit #(.IR_W(32), .OPCODE_W(5), .HALT_ON_ILLEGAL(HALT_ILL)) dut (
      .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff),
`ifdef CU_STOP_PIN_EN
      .stop(stop),
`endif
      .run(run), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout),
      .IN_Portout(IN_Portout), .LOout(LOout), .HIout(HIout), .BAout(BAout), .Rout(Rout),
      .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn), .IncPC(IncPC), .HiIn(HiIn),
      .LoIn(LoIn), .CIn(CIn), .InIn(InIn), .OutIn(OutIn), .ZIn(ZIn), .CONIn(CONIn), .RIn(RIn),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .read(read), .write(write), .add(add), .subtract(subtract),
      .multiply(multiply), .divide(divide), .andSignal(andSignal), .orSignal(orSignal)
   );

   assign act = {orSignal, andSignal, divide, multiply, subtract, add, write, read, Grc, Grb, Gra,
                 RIn, CONIn, ZIn, OutIn, InIn, CIn, LoIn, HiIn, IncPC, YIn, IRIn, MDRIn, PCIn, MARIn,
                 Rout, BAout, HIout, LOout, IN_Portout, Cout, MDRout, Zhighout, Zlowout, PCout, run};

   // Monitor: one expected vector per falling edge while the scoreboard holds entries.
   always @(negedge clk) begin
      vec_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (act !== e)
            $display("FAIL ctrl_vec t=%0t got=%09h want=%09h diff=%09h", $time, act, e, act ^ e);
         else
            passed++;
      end
   end

   function automatic vec_t alu_mask(input logic [4:0] op);
      case (op)
         5'b00011: return ADD;
         5'b00100: return SUB;
         5'b01001: return ANDS;
         5'b01010: return ORS;
         5'b01110: return MUL;
         5'b01111: return DIV;
         default:  return '0;
      endcase
   endfunction

   // Reference model: fills mdl_q with the per-clock control sets; returns 1 if the instruction ends in HALT.
   function automatic bit model_instr(input logic [4:0] op, input bit cf, input bit stp);
      vec_t ex[$];
      bit   to_halt = 1'b0;
      mdl_q.delete();
      case (op)
         5'b00011, 5'b00100, 5'b01001, 5'b01010: begin
            ex.push_back(GRB | ROUT | YIN);
            ex.push_back(GRC | ROUT | ZIN | alu_mask(op));
            ex.push_back(ZLOW | GRA | RIN);
         end
         5'b01011: begin
            ex.push_back(GRB | ROUT | YIN);
            ex.push_back(COUT | ADD | ZIN);
            ex.push_back(ZLOW | GRA | RIN);
         end
         5'b00001: begin
            ex.push_back(GRB | BAOUT | YIN);
            ex.push_back(COUT | ADD | ZIN);
            ex.push_back(ZLOW | GRA | RIN);
         end
         5'b01110, 5'b01111: begin
            ex.push_back(GRA | ROUT | YIN);
            ex.push_back(GRB | ROUT | ZIN | alu_mask(op));
            ex.push_back(ZLOW | LOIN);
            ex.push_back(ZHIGH | HIIN);
         end
         5'b10111: ex.push_back(GRA | RIN | HIOUT);
         5'b11000: ex.push_back(GRA | RIN | LOOUT);
         5'b10101: ex.push_back(GRA | RIN | INPORT);
         5'b10110: ex.push_back(GRA | ROUT | OUTIN);
         5'b10010: begin
            ex.push_back(GRA | ROUT | CONIN);
            ex.push_back(PCOUT | YIN);
            ex.push_back(COUT | ADD | ZIN);
            ex.push_back(ZLOW | (cf ? PCIN : vec_t'(0)));
         end
         5'b11001: ex.push_back('0);
         5'b11010: begin ex.push_back('0); to_halt = 1'b1; end
         default:  begin ex.push_back('0); to_halt = HALT_ILL; end
      endcase
      if (stp) to_halt = 1'b1;
      mdl_q.push_back(RUN | PCOUT | MARIN | INCPC | ZIN);
      mdl_q.push_back(RUN | ZLOW | PCIN | RD | MDRIN);
      mdl_q.push_back(RUN | MDROUT | IRIN);
      foreach (ex[i]) mdl_q.push_back(ex[i] | RUN);
      return to_halt;
   endfunction

   // Entered and left 1 time unit after a rising edge; ends with the DUT in FETCH0.
   task automatic reset_seq(input int hold);
      clr = 1'b0;
      exp_q.push_back('0);
      repeat (hold) begin
         @(posedge clk); #1;
         exp_q.push_back('0);
      end
      clr = 1'b1;
      @(posedge clk); #1;
   endtask

   // cut>0: assert clr after that many clocks of the instruction instead of completing it.
   task automatic run_instr(input logic [31:0] iw, input bit cf, input bit stp, input int cut,
                            input int halt_cycles);
      bit to_halt;
      int n;
      to_halt = model_instr(iw[31:27], cf, stp);
      ir      = iw;
      con_ff  = cf;
`ifdef CU_STOP_PIN_EN
      stop    = stp;
`endif
      n = (cut > 0 && cut < mdl_q.size()) ? cut : mdl_q.size();
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(mdl_q[i]);
         @(posedge clk); #1;
      end
`ifdef CU_STOP_PIN_EN
      stop = 1'b0;
`endif
      if (cut > 0) begin
         reset_seq(1);
      end else if (to_halt) begin
         repeat (halt_cycles) begin
            exp_q.push_back('0);
            @(posedge clk); #1;
         end
         reset_seq(1);
      end
   endtask

   initial begin
      logic [4:0] legal [15];
      legal = '{5'b00001, 5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
                5'b10010, 5'b10101, 5'b10110, 5'b10111, 5'b11000, 5'b11001, 5'b11010};
      @(posedge clk); #1;
      reset_seq(2);
      run_instr(32'h18918000, 1'b0, 1'b0, 4, 0);             // clr asserted on entry to add T4
      run_instr(32'h18918000, 1'b0, 1'b0, 0, 0);             // add r1,r2,r3
      run_instr(32'hC2800000, 1'b1, 1'b0, 0, 0);             // mflo r5
      run_instr({5'b01110, 27'h0123456}, 1'b0, 1'b0, 0, 0);  // mul
      run_instr({5'b01111, 27'h0654321}, 1'b1, 1'b0, 0, 0);  // div
      run_instr({5'b10010, 27'h1000004}, 1'b0, 1'b0, 0, 0);  // br, condition false
      run_instr({5'b10010, 27'h1000004}, 1'b1, 1'b0, 0, 0);  // br, condition true
      run_instr({5'b11111, 27'h7FFFFFF}, 1'b1, 1'b0, 0, 0);  // illegal
      run_instr({5'b11010, 27'h0}, 1'b0, 1'b0, 0, 20);       // halt
`ifdef CU_STOP_PIN_EN
      run_instr({5'b11001, 27'h0}, 1'b0, 1'b1, 0, 5);        // stop during nop T3
`endif
      for (int k = 0; k < 150; k++) begin
         logic [4:0] op;
         bit         stp;
         int         cut;
         stp = 1'b0;
`ifdef CU_STOP_PIN_EN
         stp = ($urandom_range(0, 15) == 0);
`endif
         op  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : legal[$urandom_range(0, 14)];
         cut = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 4)) : 0;
         run_instr({op, 27'($urandom)}, 1'($urandom), stp, cut, 3);
      end
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
